// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for a 5-stage MIPS pipeline: load-use and branch-operand
// hazards, taken-branch/jump squash, plus saturating stall and flush statistics.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_WriteReg,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_RegisterRd,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             IF_ID_UsesRt,
    input  logic             beq,
    input  logic             bne,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             ID_EX_Flush,
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       last_cause,
    output logic             state_dbg_o
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_LOAD_USE  = 2'd1;
    localparam logic [1:0] CAUSE_ALU_BR    = 2'd2;
    localparam logic [1:0] CAUSE_LOAD_BR   = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [1:0]       last_cause_q, last_cause_d;

    logic       br;
    logic       match_ex, match_mem;
    logic       h1, h2, h3;
    logic       in_hold;
    logic       stall;
    logic       squash;
    logic [1:0] cause_code;

    // r0 is hard-wired zero, so it can never be a true producer.
    assign match_ex  = (ID_EX_WriteReg != 5'd0) &&
                       ((ID_EX_WriteReg == IF_ID_RegisterRs) ||
                        (IF_ID_UsesRt && (ID_EX_WriteReg == IF_ID_RegisterRt)));
    assign match_mem = (EX_MEM_RegisterRd != 5'd0) &&
                       ((EX_MEM_RegisterRd == IF_ID_RegisterRs) ||
                        (IF_ID_UsesRt && (EX_MEM_RegisterRd == IF_ID_RegisterRt)));

    assign br = beq | bne;
    assign h1 = ID_EX_MemRead && match_ex;
    assign h2 = br && ID_EX_RegWrite && !ID_EX_MemRead && match_ex;
    assign h3 = br && EX_MEM_MemRead && match_mem;

    // While reset is asserted the unit behaves as if it were in RUN.
    assign in_hold = (state_q == HOLD) && !reset;

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        cause_code = CAUSE_NONE;
        if (h1) begin
            cause_code = CAUSE_LOAD_USE;
        end else if (h3) begin
            cause_code = CAUSE_LOAD_BR;
        end else if (h2) begin
            cause_code = CAUSE_ALU_BR;
        end
        if (in_hold) begin
            stall   = 1'b1;
            state_d = RUN;
        end else begin
            stall   = h1 | h2 | h3;
            state_d = (h1 && br) ? HOLD : RUN;
        end
    end

    // A stalled taken branch is squashed only in the cycle it resolves.
    assign squash      = !stall && ((br && branch_taken) || jump);
    assign PCWrite     = !stall;
    assign IF_IDWrite  = !stall;
    assign ID_EX_Flush = stall;
    assign IF_ID_Flush = squash;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        last_cause_d   = last_cause_q;
        if (stall && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
        if (squash && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end
        if (stall && !in_hold) begin
            last_cause_d = cause_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            last_cause_q   <= CAUSE_NONE;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            last_cause_q   <= last_cause_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign last_cause   = last_cause_q;
    assign state_dbg_o  = state_q;

endmodule
